// File: rtl/segrun_pkg.sv
// Shared types and glyph tables for the seven-segment display engine.
// Glyphs are active-high, bit order {g,f,e,d,c,b,a}.
package segrun_pkg;

    typedef enum logic [1:0] {LOCK, GAME, SCORE} mode_t;
    typedef enum logic [1:0] {IDLE, CONV, DONE} cstate_t;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] GLYPH_0     = 7'h3F;
    localparam logic [6:0] GLYPH_1     = 7'h06;
    localparam logic [6:0] GLYPH_2     = 7'h5B;
    localparam logic [6:0] GLYPH_3     = 7'h4F;
    localparam logic [6:0] GLYPH_4     = 7'h66;
    localparam logic [6:0] GLYPH_5     = 7'h6D;
    localparam logic [6:0] GLYPH_6     = 7'h7D;
    localparam logic [6:0] GLYPH_7     = 7'h07;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h6F;
    localparam logic [6:0] GLYPH_DASH  = 7'h40;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;
    localparam logic [6:0] GLYPH_FULL  = 7'h7F;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0:    return GLYPH_0;
            4'd1:    return GLYPH_1;
            4'd2:    return GLYPH_2;
            4'd3:    return GLYPH_3;
            4'd4:    return GLYPH_4;
            4'd5:    return GLYPH_5;
            4'd6:    return GLYPH_6;
            4'd7:    return GLYPH_7;
            4'd8:    return GLYPH_8;
            4'd9:    return GLYPH_9;
            default: return GLYPH_BLANK;
        endcase
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift per cycle for SCORE_W cycles.
// bcd is valid in the cycle done is high (last shift is combinational).
module bin2bcd_seq
    import segrun_pkg::*;
#(
    parameter int SCORE_W    = 14,
    parameter int NUM_DIGITS = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [SCORE_W-1:0]          value,
    output logic                        busy,
    output logic                        done,
    output logic [NUM_DIGITS-1:0][3:0]  bcd
);
    localparam int CW = $clog2(SCORE_W + 1);
    localparam longint unsigned MAXV = pow10(NUM_DIGITS) - 1;

    logic [SCORE_W-1:0]         bin_q, bin_nx;
    logic [NUM_DIGITS-1:0][3:0] acc_q, adj, acc_nx;
    logic [CW-1:0]              cnt_q;
    logic                       sat_q;

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++)
            adj[i] = (acc_q[i] >= 4'd5) ? acc_q[i] + 4'd3 : acc_q[i];
        {acc_nx, bin_nx} = {adj, bin_q} << 1;
    end

    assign done = busy && (cnt_q == CW'(SCORE_W - 1));
    assign bcd  = sat_q ? {NUM_DIGITS{4'd9}} : acc_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= 1'b0;
            cnt_q <= '0;
            bin_q <= '0;
            acc_q <= '0;
            sat_q <= 1'b0;
        end else if (start) begin
            bin_q <= value;
            acc_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b1;
            sat_q <= 64'(value) > MAXV;
        end else if (abort) begin
            busy <= 1'b0;
        end else if (busy) begin
            acc_q <= acc_nx;
            bin_q <= bin_nx;
            cnt_q <= cnt_q + 1'b1;
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/segment_display_engine.sv
// Seven-segment display bank driver: LOCK / GAME / SCORE views behind an
// input sample stage and a registered, polarity-adjusted output.
module segment_display_engine
    import segrun_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int SCORE_W    = 14,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    loggedIn,
    input  logic [NUM_DIGITS-1:0]   ceilingBits,
    input  logic [NUM_DIGITS-1:0]   floorBits,
    input  logic                    playerPos,
    input  logic [SCORE_W-1:0]      score,
    input  logic                    showScore,
    input  logic                    blinkTick,
    output logic [7*NUM_DIGITS-1:0] disp,
    output logic                    busy
);
    localparam int L = NUM_DIGITS - 1;

    mode_t                      mode_q;
    cstate_t                    state_q;
    logic [NUM_DIGITS-1:0]      ceil_q, floor_q, lz;
    logic                       pos_q, phase_q, pend_q, have_q;
    logic [SCORE_W-1:0]         score_q, lat_q;
    logic [NUM_DIGITS-1:0][3:0] digits_q, conv_bcd, show_dig;
    logic [NUM_DIGITS-1:0][6:0] seg, disp_q;
    logic                       conv_start, conv_abort, conv_done, in_score;
    logic                       show_have, collide;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= LOCK;
            ceil_q  <= '0;
            floor_q <= '0;
            pos_q   <= 1'b0;
            score_q <= '0;
            phase_q <= 1'b1;
        end else begin
            mode_q  <= !loggedIn ? LOCK : (showScore ? SCORE : GAME);
            ceil_q  <= ceilingBits;
            floor_q <= floorBits;
            pos_q   <= playerPos;
            score_q <= score;
            if (blinkTick) phase_q <= ~phase_q;
        end
    end

    assign in_score = (mode_q == SCORE);

    always_comb begin
        conv_start = 1'b0;
        conv_abort = 1'b0;
        case (state_q)
            IDLE: conv_start = in_score;
            CONV: begin
                if (!in_score) conv_abort = 1'b1;
                else if (conv_done && (pend_q || score_q != lat_q)) conv_start = 1'b1;
            end
            DONE:    conv_start = in_score && (score_q != lat_q);
            default: ;
        endcase
    end

    // A conversion always runs to completion on a score change; the newest
    // score is picked up afterwards via pend_q so no stale value is shown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            pend_q   <= 1'b0;
            have_q   <= 1'b0;
            digits_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    have_q <= 1'b0;
                    pend_q <= 1'b0;
                    if (conv_start) begin
                        state_q <= CONV;
                        lat_q   <= score_q;
                    end
                end
                CONV: begin
                    if (!in_score) begin
                        state_q <= IDLE;
                        pend_q  <= 1'b0;
                        have_q  <= 1'b0;
                    end else if (conv_done) begin
                        digits_q <= conv_bcd;
                        have_q   <= 1'b1;
                        if (conv_start) begin
                            lat_q  <= score_q;
                            pend_q <= 1'b0;
                        end else begin
                            state_q <= DONE;
                        end
                    end else if (score_q != lat_q) begin
                        lat_q  <= score_q;
                        pend_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (!in_score) begin
                        state_q <= IDLE;
                        have_q  <= 1'b0;
                    end else if (conv_start) begin
                        state_q <= CONV;
                        lat_q   <= score_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    bin2bcd_seq #(.SCORE_W(SCORE_W), .NUM_DIGITS(NUM_DIGITS)) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .abort (conv_abort),
        .value (score_q),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Bypass the digit register on completion so new digits land on disp
    // at the same edge busy falls.
    assign show_dig  = (conv_done && in_score) ? conv_bcd : digits_q;
    assign show_have = have_q || (conv_done && in_score);
    assign collide   = pos_q ? ceil_q[L] : floor_q[L];

    always_comb begin
        lz[L] = (show_dig[L] == 4'd0);
        for (int i = L - 1; i >= 0; i--)
            lz[i] = lz[i+1] && (show_dig[i] == 4'd0);
    end

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            seg[i] = GLYPH_DASH;
            if (mode_q == GAME) begin
                seg[i] = GLYPH_BLANK;
                seg[i][SEG_A] = ceil_q[i];
                seg[i][SEG_D] = floor_q[i];
                if (i == L) begin
                    seg[i][pos_q ? SEG_F : SEG_E] = 1'b1;
                    if (collide) seg[i] = phase_q ? GLYPH_FULL : GLYPH_BLANK;
                end
            end else if (mode_q == SCORE) begin
                seg[i] = (!show_have || (lz[i] && i != 0)) ? GLYPH_BLANK
                                                           : digit_glyph(show_dig[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) disp_q <= ACTIVE_LOW ? '1 : '0;
        else     disp_q <= ACTIVE_LOW ? ~seg : seg;
    end

    assign disp = disp_q;

endmodule

// File: tb/tb_segment_display_engine.sv
// Directed bench: table of GAME/LOCK vectors plus hand-written score,
// blink, abort and reset sequences on a 6-digit and a 4-digit instance.
module tb_segment_display_engine;

    localparam logic [6:0] OFF   = 7'h7F;
    localparam logic [6:0] DASH  = 7'h3F;
    localparam logic [6:0] ZERO  = 7'h40;
    localparam logic [6:0] ONE   = 7'h79;
    localparam logic [6:0] TWO   = 7'h24;
    localparam logic [6:0] THREE = 7'h30;
    localparam logic [6:0] FOUR  = 7'h19;
    localparam logic [6:0] SIX   = 7'h02;
    localparam logic [6:0] EIGHT = 7'h00;
    localparam logic [6:0] NINE  = 7'h10;

    logic        clk = 1'b0;
    logic        rst;
    logic        li, ss, pp, bt;
    logic [5:0]  ce, fl;
    logic [13:0] sc;
    logic [41:0] disp6;
    logic [27:0] disp4;
    logic        busy6, busy4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    segment_display_engine #(.NUM_DIGITS(6), .SCORE_W(14), .ACTIVE_LOW(1'b1)) dut6 (
        .clk(clk), .rst(rst), .loggedIn(li), .ceilingBits(ce), .floorBits(fl),
        .playerPos(pp), .score(sc), .showScore(ss), .blinkTick(bt),
        .disp(disp6), .busy(busy6)
    );

    segment_display_engine #(.NUM_DIGITS(4), .SCORE_W(14), .ACTIVE_LOW(1'b1)) dut4 (
        .clk(clk), .rst(rst), .loggedIn(li), .ceilingBits(ce[3:0]), .floorBits(fl[3:0]),
        .playerPos(pp), .score(sc), .showScore(ss), .blinkTick(bt),
        .disp(disp4), .busy(busy4)
    );

    typedef struct {
        logic        li, ss, pp;
        logic [5:0]  ce, fl;
        logic [41:0] exp;
    } vec_t;

    vec_t tv[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    initial begin
        tv[0] = '{li:1'b0, ss:1'b0, pp:1'b0, ce:6'h00,      fl:6'h00,      exp:{6{DASH}}};
        tv[1] = '{li:1'b1, ss:1'b0, pp:1'b0, ce:6'b111111,  fl:6'h00,      exp:{7'h6E, {5{7'h7E}}}};
        tv[2] = '{li:1'b1, ss:1'b0, pp:1'b1, ce:6'h00,      fl:6'h00,      exp:{7'h5F, {5{OFF}}}};
        tv[3] = '{li:1'b1, ss:1'b0, pp:1'b0, ce:6'b000101,  fl:6'b010010,
                  exp:{7'h6F, 7'h77, OFF, 7'h7E, 7'h77, 7'h7E}};
        tv[4] = '{li:1'b1, ss:1'b0, pp:1'b0, ce:6'b100000,  fl:6'b000011,
                  exp:{7'h6E, OFF, OFF, OFF, 7'h77, 7'h77}};
        tv[5] = '{li:1'b1, ss:1'b0, pp:1'b0, ce:6'h00,      fl:6'b100000,  exp:{7'h00, {5{OFF}}}};
        tv[6] = '{li:1'b1, ss:1'b0, pp:1'b1, ce:6'b100001,  fl:6'h00,
                  exp:{7'h00, OFF, OFF, OFF, OFF, 7'h7E}};
        tv[7] = '{li:1'b0, ss:1'b0, pp:1'b0, ce:6'b111111,  fl:6'b111111,  exp:{6{DASH}}};
        tv[8] = '{li:1'b0, ss:1'b1, pp:1'b0, ce:6'h00,      fl:6'h00,      exp:{6{DASH}}};
        tv[9] = '{li:1'b1, ss:1'b0, pp:1'b1, ce:6'h00,      fl:6'b100000,  exp:{7'h57, {5{OFF}}}};

        rst = 1'b1; li = 0; ss = 0; pp = 0; bt = 0; ce = '0; fl = '0; sc = '0;
        #12;
        check("reset_disp6", 64'(disp6), 64'({6{OFF}}));
        check("reset_disp4", 64'(disp4), 64'({4{OFF}}));
        check("reset_busy",  64'({busy6, busy4}), 64'd0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            li = tv[i].li; ss = tv[i].ss; pp = tv[i].pp; ce = tv[i].ce; fl = tv[i].fl;
            tick();
            tick();
            check($sformatf("vec%0d_disp", i), 64'(disp6), 64'(tv[i].exp));
            check($sformatf("vec%0d_busy", i), 64'(busy6), 64'd0);
        end

        // score 9999 from SCORE entry
        li = 1; ss = 0; pp = 0; ce = '0; fl = '0; sc = 14'd9999;
        tick(); tick();
        ss = 1;
        tick();
        check("s9999_busy_e0", 64'(busy6), 64'd0);
        for (int k = 1; k <= 14; k++) begin
            tick();
            check($sformatf("s9999_busy%0d", k), 64'(busy6), 64'd1);
            check($sformatf("s9999_blank%0d", k), 64'(disp6), 64'({6{OFF}}));
        end
        tick();
        check("s9999_busy_end", 64'(busy6), 64'd0);
        check("s9999_disp6", 64'(disp6), 64'({OFF, OFF, {4{NINE}}}));
        check("s9999_disp4", 64'(disp4), 64'({4{NINE}}));

        // change 9999 -> 42 during the 5th busy cycle
        ss = 0;
        tick(); tick();
        ss = 1;
        tick();
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 5) sc = 14'd42;
            check($sformatf("chg_busy%0d", k), 64'(busy6), 64'd1);
        end
        tick();
        check("chg_busy_restart", 64'(busy6), 64'd1);
        check("chg_disp_first", 64'(disp6), 64'({OFF, OFF, {4{NINE}}}));
        for (int k = 16; k <= 28; k++) begin
            tick();
            check($sformatf("chg_busy%0d", k), 64'(busy6), 64'd1);
        end
        check("chg_hold9999", 64'(disp6), 64'({OFF, OFF, {4{NINE}}}));
        tick();
        check("chg_busy_end", 64'(busy6), 64'd0);
        check("chg_disp6_42", 64'(disp6), 64'({{4{OFF}}, FOUR, TWO}));
        check("chg_disp4_42", 64'(disp4), 64'({OFF, OFF, FOUR, TWO}));

        // leave SCORE mid-conversion
        sc = 14'd9999;
        tick(); tick(); tick(); tick();
        check("abort_busy_pre", 64'(busy6), 64'd1);
        ss = 0;
        tick();
        check("abort_busy_same", 64'(busy6), 64'd1);
        tick();
        check("abort_busy", 64'(busy6), 64'd0);
        check("abort_game_view", 64'(disp6), 64'({7'h6F, {5{OFF}}}));

        // saturation on the 4-digit instance
        sc = 14'd16383; ss = 1;
        tick();
        for (int k = 1; k <= 14; k++) tick();
        check("sat_blank4", 64'(disp4), 64'({4{OFF}}));
        check("sat_busy4", 64'(busy4), 64'd1);
        tick();
        check("sat_disp4", 64'(disp4), 64'({4{NINE}}));
        check("sat_disp6", 64'(disp6), 64'({OFF, ONE, SIX, THREE, EIGHT, THREE}));
        check("sat_busy4_end", 64'(busy4), 64'd0);

        // score 0: single rightmost zero; previous digits held meanwhile
        sc = 14'd0;
        tick();
        for (int k = 1; k <= 14; k++) tick();
        check("zero_hold4", 64'(disp4), 64'({4{NINE}}));
        check("zero_busy4", 64'(busy4), 64'd1);
        tick();
        check("zero_disp4", 64'(disp4), 64'({OFF, OFF, OFF, ZERO}));
        check("zero_disp6", 64'(disp6), 64'({{5{OFF}}, ZERO}));
        check("zero_busy6", 64'(busy6), 64'd0);

        // collision blink
        ss = 0; pp = 1; ce = 6'b100000; fl = '0;
        tick(); tick();
        check("blink0", 64'(disp6[41:35]), 64'(7'h00));
        for (int p = 1; p <= 3; p++) begin
            bt = 1;
            tick();
            bt = 0;
            tick();
            check($sformatf("blink%0d", p), 64'(disp6[41:35]), (p % 2 == 1) ? 64'(7'h7F) : 64'(7'h00));
        end

        // asynchronous reset mid-conversion
        ss = 1; sc = 14'd123;
        tick(); tick(); tick();
        check("rst_busy_pre", 64'(busy6), 64'd1);
        rst = 1'b1;
        #2;
        check("rst_async_disp6", 64'(disp6), 64'({6{OFF}}));
        check("rst_async_disp4", 64'(disp4), 64'({4{OFF}}));
        check("rst_async_busy", 64'({busy6, busy4}), 64'd0);
        tick();
        rst = 1'b0; ss = 0; pp = 1; ce = 6'b100000; fl = '0;
        tick(); tick();
        check("rst_phase_one", 64'(disp6[41:35]), 64'(7'h00));
        check("rst_busy_post", 64'(busy6), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/segment_display_engine.md
# segment_display_engine

Registered, parametrised driver for the game's seven-segment display bank. Each frame it renders one of three views on `NUM_DIGITS` digits: a locked pattern, the lane view, or the decimal score. The score comes from an internal multi-cycle binary-to-BCD converter, with saturation and leading-zero blanking. The block sits between the game core (lane bits, player position, score) and the board's display pins, and replaces the fixed six-digit combinational decoder.

## Interface
- `NUM_DIGITS`, 6: number of digits and lane columns; must be ≥2.
- `SCORE_W`, 14: score width in bits.
- `ACTIVE_LOW`, 1: 1 means a lit segment drives 0.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `loggedIn` in 1: 0 selects the locked view.
- `ceilingBits` in `NUM_DIGITS`: obstacle present in the top lane; bit i maps to digit i, and digit `NUM_DIGITS-1` is leftmost.
- `floorBits` in `NUM_DIGITS`: obstacle present in the bottom lane.
- `playerPos` in 1: 1 means the player is in the top lane, 0 the bottom lane.
- `score` in `SCORE_W`: unsigned binary score.
- `showScore` in 1: 1 selects the score view (only when `loggedIn`=1).
- `blinkTick` in 1: single-cycle pulse that toggles the blink phase.
- `disp` out `7*NUM_DIGITS`: digit i on `disp[7i+6:7i]`, bit order {g,f,e,d,c,b,a}.
- `busy` out 1: conversion in progress.

## Operation
- Segment polarity: polarity is applied at the output register, and every glyph below is defined active-high before polarity. An off digit is 7'h00 before polarity, so it drives 7'h7F when `ACTIVE_LOW`=1.
- Mode select, registered each cycle:
  - `loggedIn`=0 selects LOCK.
  - `loggedIn`=1 with `showScore`=0 selects GAME.
  - `loggedIn`=1 with `showScore`=1 selects SCORE.
- LOCK view: every digit shows segment g only (a dash).
- GAME view, per digit i:
  - segment a = `ceilingBits[i]`, segment d = `floorBits[i]`.
  - The leftmost digit also shows the player: segment f if `playerPos`=1, segment e if `playerPos`=0.
  - Collision = the obstacle bit of the player's lane at digit `NUM_DIGITS-1`.
  - On collision, the leftmost digit shows all seven segments when blink phase=1 and is off when phase=0.
- Blink phase: resets to 1 and toggles on each `blinkTick` cycle, independent of mode.
- SCORE view, converter FSM with states IDLE, CONV, DONE:
  - IDLE→CONV when SCORE mode is entered, or when `score` differs from the latched value while in SCORE. This latches `score`.
  - CONV performs one double-dabble shift per cycle for `SCORE_W` cycles, then →DONE, loading the BCD result into a digit register.
  - DONE→CONV when the score changes. DONE→IDLE when SCORE mode is left.
  - A score change during CONV sets a pending flag. The current conversion completes, then CONV restarts with the new score; intermediate scores are never displayed.
- Saturation: if the latched score > 10^`NUM_DIGITS`−1, the result is all digits 9. The comparison is made at latch time.
- Leading-zero blanking: leading zero digits are off. A score of 0 shows a single "0" on the rightmost digit.
- Score display content: on SCORE entry the display is blank until the first conversion completes. On later score changes the display holds the previous digits until the new conversion completes.
- Leaving SCORE mid-conversion aborts it: the FSM goes to IDLE and the pending flag clears.

## Timing
- Reset values:
  - `disp` = all digits off.
  - `busy`=0, FSM=IDLE, blink phase=1, digit register = 0, pending flag = 0.
- LOCK and GAME views: input sampled at edge E appears on `disp` after edge E+1, i.e. one register stage.
- SCORE latency: with the trigger sampled at edge E0, `busy` is high for exactly `SCORE_W` cycles (edges E0+1…E0+`SCORE_W`). New digits appear on `disp` after edge E0+`SCORE_W`+1.
- A mode change takes effect on `disp` one cycle after it is sampled, even if a conversion is running.
- `rst` mid-conversion: immediate return to the reset values; no completion.

## Structure
- Package `segrun_pkg` holds:
  - the mode enum (LOCK, GAME, SCORE) and the converter state enum;
  - glyph constants: digits 0–9, dash, blank, full;
  - segment bit-index constants.
- Sub-module `bin2bcd_seq`: the sequential double-dabble converter with start/busy/done handshake, parametrised by `SCORE_W` and `NUM_DIGITS`, including saturation.
- The top level holds mode select, the glyph mux, blink, blanking and the output register.

## Test plan
- Reset: assert `rst` mid-run → `disp`=all 7'h7F, `busy`=0, with no clock edge required.
- LOCK→GAME: `loggedIn` 0→1 with ceiling=6'b111111, floor=0, `playerPos`=0 → digits 0–4 = 7'h7E. Digit 5 = 7'h6E (a + e lit, active-low).
- Collision blink: `playerPos`=1, ceiling bit 5 set, three `blinkTick` pulses → the leftmost digit alternates 7'h00 / 7'h7F.
- Score 14'b10011100001111 (9999): `showScore`↑ → `busy` high 14 cycles, display blank, then "  9999" (two blank digits, then four 9s).
- Score change during conversion (9999→42 at the 5th busy cycle) → "9999" is shown, then a second 14-cycle conversion, then "    42". `showScore`↓ mid-conversion → GAME view next cycle and `busy`=0.
- With `NUM_DIGITS`=4, score 16383 → "9999" (saturated). Score 0 → only the rightmost digit lit, showing "0".
